// File: rtl/seq_lut_gen.sv
// Table-driven sequence generator: the state walks Y <= TABLE[Y] under a small
// IDLE/RUN/HALT controller, with a saturating step count and seed-return detection.
module seq_lut_gen #(
   parameter int unsigned W           = 4,
   parameter int unsigned CW          = 8,
   parameter bit          STOP_ON_CYC = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [W-1:0]  wa_i,
   input  logic [W-1:0]  wd_i,
   input  logic          load_i,
   input  logic [W-1:0]  seed_i,
   input  logic          run_i,
   input  logic          step_i,
   output logic [W-1:0]  y_o,
   output logic [CW-1:0] cnt_o,
   output logic          cyc_o,
   output logic          fix_o,
   output logic          busy_o
);

   localparam int unsigned Depth = 2 ** W;

   // Entry i of the 4-bit power-on table lives in bits [4*i +: 4].
   localparam logic [63:0] Def4 = {4'h5, 4'h5, 4'h9, 4'hA, 4'hB, 4'h4, 4'hC, 4'hF,
                                   4'h5, 4'h0, 4'h6, 4'hC, 4'h1, 4'hA, 4'h2, 4'h2};

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   tbl_q [Depth];
   logic [W-1:0]   y_q, y_d;
   logic [W-1:0]   seed_q, seed_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           cyc_q, cyc_d;
   logic [W-1:0]   next_y;
   logic           hit;
   logic           adv;

   function automatic logic [W-1:0] tbl_init(input int unsigned idx);
      logic [3:0] i4;
      i4 = idx[3:0];
      if (W == 4) begin
         return W'(Def4[{i4, 2'b00} +: 4]);
      end
      return W'(idx + 1);
   endfunction

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      seed_d  = seed_q;
      cnt_d   = cnt_q;
      cyc_d   = 1'b0;
      adv     = 1'b0;
      // Reads the table before any same-edge write lands.
      next_y  = tbl_q[y_q];
      hit     = (next_y == seed_q);

      if (load_i) begin
         y_d     = seed_i;
         seed_d  = seed_i;
         cnt_d   = '0;
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               adv = run_i | step_i;
               if (run_i) begin
                  state_d = (hit && STOP_ON_CYC) ? StHalt : StRun;
               end
            end
            StRun: begin
               if (run_i) begin
                  adv = 1'b1;
                  if (hit && STOP_ON_CYC) begin
                     state_d = StHalt;
                  end
               end else begin
                  state_d = StIdle;
               end
            end
            StHalt: begin
               state_d = StHalt;
            end
            default: begin
               state_d = StIdle;
            end
         endcase

         if (adv) begin
            y_d   = next_y;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
            cyc_d = hit;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         y_q     <= '0;
         seed_q  <= '0;
         cnt_q   <= '0;
         cyc_q   <= 1'b0;
         for (int unsigned i = 0; i < Depth; i++) begin
            tbl_q[W'(i)] <= tbl_init(i);
         end
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         seed_q  <= seed_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         if (we_i) begin
            tbl_q[wa_i] <= wd_i;
         end
      end
   end

   assign y_o    = y_q;
   assign cnt_o  = cnt_q;
   assign cyc_o  = cyc_q;
   assign busy_o = (state_q == StRun);
   assign fix_o  = (tbl_q[y_q] == y_q);

endmodule

// File: doc/seq_lut_gen.md
SEQ_LUT_GEN -- requirements
Module: seq_lut_gen

Interface
REQ-001 Parameter W, default 4: state/data width in bits; the table has 2^W entries of W bits.
REQ-002 Parameter CW, default 8: step-counter width in bits.
REQ-003 Parameter STOP_ON_CYC, default 1: 1 = halt automatically on seed return; 0 = keep running.
REQ-004 CLK  in  1  single clock, all state updates on its rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 WE  in  1  table write enable.
REQ-007 WA  in  W  table write address.
REQ-008 WD  in  W  table write data.
REQ-009 LOAD  in  1  load SEED into the state register and the seed register.
REQ-010 SEED  in  W  start value.
REQ-011 RUN  in  1  level; advance one step per cycle while high.
REQ-012 STEP  in  1  single-cycle pulse; advance exactly one step.
REQ-013 Y  out  W  current state, registered.
REQ-014 CNT  out  CW  steps taken since the last LOAD, registered, saturating.
REQ-015 CYC  out  1  one-cycle pulse when an advance lands on the stored seed.
REQ-016 FIX  out  1  level; high while TABLE[Y] == Y (fixed point).
REQ-017 BUSY  out  1  level; high in the RUN state.

Function
REQ-018 Advance SHALL be Y <= TABLE[Y], where TABLE is an internal 2^W x W array; CNT <= CNT+1, saturating at 2^CW-1.
REQ-019 FSM states SHALL be IDLE, RUN and HALT.
REQ-020 IDLE -> RUN when RUN=1; IDLE: STEP=1 performs one advance and stays in IDLE.
REQ-021 RUN: advance every cycle; RUN=0 -> IDLE (no advance in that cycle).
REQ-022 HALT is entered from RUN on the cycle CYC is asserted if STOP_ON_CYC=1; in HALT, RUN and STEP are ignored; only LOAD or RST exit.
REQ-023 LOAD has priority over RUN and STEP: Y <= SEED, seed register <= SEED, CNT <= 0, state <= IDLE, no advance that cycle.
REQ-024 STEP in RUN state SHALL have no additional effect (max one advance per cycle).
REQ-025 CYC SHALL be asserted for one cycle in the cycle after any advance whose new Y equals the seed register; advances from LOAD never assert CYC.
REQ-026 FIX SHALL be combinational on the registered Y and the current TABLE contents.
REQ-027 WE SHALL write TABLE[WA] <= WD on the clock edge, independent of FSM state and LOAD.
REQ-028 Simultaneous WE and advance with WA == Y: the advance SHALL use the old TABLE[Y] (read-before-write); the new value takes effect from the next cycle.
REQ-029 The step count continues to saturate; CNT SHALL never wrap.
REQ-030 Latency: Y, CNT, BUSY and CYC update one clock after the causing input is sampled.

Reset
REQ-031 On RST=1 at a clock edge: Y=0, CNT=0, seed register=0, CYC=0, state=IDLE (BUSY=0); RST overrides all inputs.
REQ-032 For W=4, reset SHALL load TABLE[0..F] = 2,2,A,1,C,6,0,5,F,C,4,B,A,9,5,5.
REQ-033 For W != 4, reset SHALL load TABLE[i] = (i+1) mod 2^W.
REQ-034 RST asserted mid-run SHALL discard all runtime table writes and state within the same edge.

Verification
REQ-035 Reset, LOAD SEED=0, RUN=1 for 6 cycles -> Y sequence 2,A,4,C,A,4; CNT=6; CYC never asserted.
REQ-036 LOAD SEED=A, RUN=1 -> Y 4,C,A; CYC pulses once with Y=A and CNT=3; the FSM enters HALT, BUSY=0, and Y stays A with RUN held.
REQ-037 LOAD SEED=B, then a STEP pulse -> Y=B, CNT=1, FIX=1 throughout; CYC pulses (B returns to seed).
REQ-038 Y=3, WE with WA=3, WD=7 plus STEP in the same cycle -> Y=1 (old entry); next STEP -> Y=2; then TABLE[3]=7 is confirmed via LOAD 3 and STEP -> Y=7.
REQ-039 CW=2, seed 0, RUN for 5 cycles -> CNT 1,2,3,3,3 (saturates).
REQ-040 RST during RUN after a table write -> next cycle: Y=0, CNT=0, BUSY=0; the default TABLE is restored (STEP from 0 gives 2).
